// File: rtl/sys_reset_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_reset_pkg : shared types and cause-bit index helpers              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sys_reset_pkg;

  typedef enum logic [1:0] {
    POR     = 2'd0,
    IDLE    = 2'd1,
    HOLD    = 2'd2,
    STRETCH = 2'd3
  } state_t;

  function automatic int cause_cfg_bit(input int nsrc);
    return nsrc;
  endfunction

  function automatic int cause_por_bit(input int nsrc);
    return nsrc + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_reset_ctrl_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop single-bit synchroniser, clears to 0 on reset    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/sys_reset_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_reset_ctrl : merges requests, PLL lock and config changes into a |
// | stretched core reset with cause reporting.            Rev 1.0        |
// +----------------------------------------------------------------------+
module sys_reset_ctrl
  import sys_reset_pkg::*;
#(
  parameter int CFG_W     = 2,
  parameter int NSRC      = 4,
  parameter int PULSE_LEN = 15
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic [CFG_W-1:0]  cfg,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC-1:0]   req_mask,
  output logic              sys_reset,
  output logic [CFG_W-1:0]  cfg_latched,
  output logic [NSRC+1:0]   cause,
  output logic              rst_done
);

  localparam int                c_CNT_W     = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(PULSE_LEN - 1);
  localparam int                c_CFG_BIT   = cause_cfg_bit(NSRC);
  localparam int                c_POR_BIT   = cause_por_bit(NSRC);
  localparam logic [NSRC+1:0]   c_CAUSE_POR = {1'b1, {(NSRC+1){1'b0}}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [NSRC+1:0]     r_cause;
  logic [NSRC+1:0]     w_cause_nxt;
  logic [CFG_W-1:0]    r_cfg_latched;
  logic [CFG_W-1:0]    w_cfg_nxt;
  logic                r_sys_reset;
  logic                r_rst_done;
  logic                w_done_nxt;
  logic                w_lock;
  logic [NSRC-1:0]     w_act;
  logic                w_cfg_chg;

  sync_2ff u_lock_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_async (pll_locked),
    .o_sync  (w_lock)
  );

  assign w_act     = req & ~req_mask;
  assign w_cfg_chg = (cfg != r_cfg_latched);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    w_cfg_nxt   = r_cfg_latched;
    w_done_nxt  = 1'b0;
    case (r_state)
      POR: begin
        if (w_lock) begin
          w_cfg_nxt   = cfg;
          w_cnt_nxt   = c_CNT_LOAD;
          w_state_nxt = STRETCH;
        end
      end
      IDLE: begin
        // cause is only cleared here, so it reads back stable while idle
        if (!w_lock) begin
          w_state_nxt = POR;
          w_cause_nxt = c_CAUSE_POR;
        end else if (|w_act) begin
          w_state_nxt = HOLD;
          w_cause_nxt = {2'b00, w_act};
          if (w_cfg_chg) begin
            w_cfg_nxt              = cfg;
            w_cause_nxt[c_CFG_BIT] = 1'b1;
          end
        end else if (w_cfg_chg) begin
          w_cfg_nxt              = cfg;
          w_cnt_nxt              = c_CNT_LOAD;
          w_state_nxt            = STRETCH;
          w_cause_nxt            = '0;
          w_cause_nxt[c_CFG_BIT] = 1'b1;
        end
      end
      HOLD: begin
        if (!w_lock) begin
          w_state_nxt            = POR;
          w_cause_nxt[c_POR_BIT] = 1'b1;
        end else begin
          w_cause_nxt = r_cause | {2'b00, w_act};
          if (w_cfg_chg) begin
            w_cfg_nxt              = cfg;
            w_cause_nxt[c_CFG_BIT] = 1'b1;
          end
          if (w_act == '0) begin
            w_cnt_nxt   = c_CNT_LOAD;
            w_state_nxt = STRETCH;
          end
        end
      end
      STRETCH: begin
        if (!w_lock) begin
          w_state_nxt            = POR;
          w_cause_nxt[c_POR_BIT] = 1'b1;
        end else if (|w_act) begin
          w_state_nxt = HOLD;
          w_cause_nxt = r_cause | {2'b00, w_act};
        end else if (w_cfg_chg) begin
          w_cfg_nxt              = cfg;
          w_cnt_nxt              = c_CNT_LOAD;
          w_cause_nxt[c_CFG_BIT] = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = POR;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= POR;
      r_cnt         <= '0;
      r_cause       <= c_CAUSE_POR;
      r_cfg_latched <= '0;
      r_sys_reset   <= 1'b1;
      r_rst_done    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cause       <= w_cause_nxt;
      r_cfg_latched <= w_cfg_nxt;
      r_sys_reset   <= (w_state_nxt != IDLE);
      r_rst_done    <= w_done_nxt;
    end
  end

  assign sys_reset   = r_sys_reset;
  assign cfg_latched = r_cfg_latched;
  assign cause       = r_cause;
  assign rst_done    = r_rst_done;

endmodule
`default_nettype wire

// File: doc/sys_reset_ctrl.md
# sys_reset_ctrl

Parametrised system reset sequencer for the machine top levels. It merges N level reset requests (OSD reset, button, ROM download, and so on), PLL lock, and a configuration vector (machine select and similar fields) into one registered, stretched `sys_reset`. A change in the configuration vector produces a fixed-length reset pulse, and the new configuration is latched for the core. It replaces the ad-hoc machine-select reset counter and OR-tree with a configurable block that also reports the reset cause.

## Interface
- `CFG_W`, default 2: width of the configuration vector.
- `NSRC`, default 4: number of reset-request sources.
- `PULSE_LEN`, default 15: stretch length in cycles. Must be ≥1.
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `pll_locked`, in, 1: PLL lock. Asynchronous, synchronised internally.
- `cfg`, in, `CFG_W`: configuration. Synchronous to `clk_sys`.
- `req`, in, `NSRC`: level reset requests. Synchronous, active-high.
- `req_mask`, in, `NSRC`: 1 = ignore that source.
- `sys_reset`, out, 1: registered active-high core reset.
- `cfg_latched`, out, `CFG_W`: configuration the core runs with.
- `cause`, out, `NSRC+2`: reset cause. Bits `[NSRC-1:0]` are requests, bit `[NSRC]` is cfg change, bit `[NSRC+1]` is POR/lock loss.
- `rst_done`, out, 1: one-cycle pulse when `sys_reset` deasserts.

## Operation
- **Reset values** (`reset_n` low): state POR, `sys_reset`=1, `cfg_latched`=0, `cause`=POR bit only, `rst_done`=0, counter=0, lock synchroniser=0.
- **Active request:** `act = req & ~req_mask`.
- **POR:** `sys_reset`=1. When the synchronised lock is 1, latch `cfg` into `cfg_latched`, load counter = `PULSE_LEN-1`, and go to STRETCH.
- **IDLE:** `sys_reset`=0. Priority order, highest first:
  - Synchronised lock = 0: go to POR. `cause` is set to the POR bit.
  - `act` ≠ 0: go to HOLD. `cause` is set to `act`.
  - `cfg` ≠ `cfg_latched`: latch `cfg`, load counter, go to STRETCH. `cause` is set to the cfg bit.
- **HOLD:** `sys_reset`=1 and `cause |= act` every cycle. A cfg change is latched immediately and sets the cfg bit. When `act` = 0, load counter and go to STRETCH. Lock loss goes to POR with `cause |=` POR bit.
- **STRETCH:** `sys_reset`=1.
  - `act` ≠ 0: go to HOLD, accumulating `cause`.
  - Else if cfg changes: re-latch, reload counter, set the cfg bit.
  - Else if counter = 0: go to IDLE and pulse `rst_done`.
  - Else decrement the counter.
  - Lock loss goes to POR and has priority over all of the above.
- **`cause`:** cleared and reloaded only when leaving IDLE, accumulated (OR) during an episode, and held stable in IDLE for software/OSD readout.
- **Arithmetic:** the counter is `$clog2(PULSE_LEN)` bits, minimum 1. It never wraps; reload is the only path up.

## Timing
- All outputs are registered. The state change and the output take effect on the same clock edge at which the condition is sampled.
- **Cfg change or request from IDLE:** sampled at edge t, `sys_reset` is high from t for exactly `PULSE_LEN` cycles after the request releases. For a cfg change alone, `sys_reset` is high for exactly `PULSE_LEN` cycles.
- **`cfg_latched`:** updates at the same edge `sys_reset` rises, so the core always sees the new configuration while in reset.
- **Lock path:** 2-flop synchroniser, giving 2 cycles from a `pll_locked` change to the FSM.
- **`rst_done`:** high during the first IDLE cycle only.
- **`reset_n` assertion mid-episode:** immediate asynchronous return to POR values. Deassertion takes effect on the next edge.
- **Simultaneous request and cfg change in IDLE:** go to HOLD. The cfg is latched and both cause bits are set.

## Structure
- **Package `sys_reset_pkg`:**
  - state enum `{POR, IDLE, HOLD, STRETCH}`
  - function `cause_cfg_bit(NSRC)` and `cause_por_bit(NSRC)` index helpers
- **Sub-module `sync_2ff`:** single-bit synchroniser used for `pll_locked`. It has `clk_sys`/`reset_n` and resets to 0.
- The main module holds the FSM, counter, and cause/cfg registers.

## Test plan
- **POR:** `pll_locked`=1 throughout, `reset_n` released at cycle 0, `PULSE_LEN`=15. Required: `sys_reset` high through cycle 17 and low at 18, `rst_done` pulse at 18, `cause` = 6'b100000 (`NSRC`=4).
- **Cfg change:** in IDLE, `cfg` 00→10. Required: `sys_reset` high exactly 15 cycles, `cfg_latched`=10 from the first of those cycles, `cause` = 6'b010000.
- **Held request:** `req[0]` held 40 cycles. Required: `sys_reset` high for 55 cycles, `cause` = 6'b000001. With `req[1]` pulsed mid-hold, `cause` = 6'b000011.
- **Restart:** cfg 00→01, then 01→11 after 10 stretch cycles. Required: counter reloads, `sys_reset` high for 25 cycles total, `cfg_latched`=11.
- **Mask and lock loss:** `req_mask[2]`=1 with `req[2]` held gives no reset. `pll_locked` dropped for 1 cycle in IDLE gives POR, `cause` bit 5 set, and `sys_reset` high ≥ 2+15 cycles after relock.
- **Async reset:** `reset_n` pulsed low mid-STRETCH, between clock edges. Required: `sys_reset`=1 and `cfg_latched`=0 immediately, then the POR sequence.
